// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

   localparam int unsigned RAM_ADDR_W = 16;
   localparam int unsigned RAM_DATA_W = 32;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } ram_arb_state_t;

endpackage

// File: rtl/RAM_32bit_16aline.sv
// 32-bit x 64K-word RAM with combinational read and clocked write.
module RAM_32bit_16aline (
   input  logic        clk,
   input  logic [15:0] address,
   input  logic [31:0] in,
   input  logic        is_write,
   output logic [31:0] out
);

   logic [31:0] mem_q [65536];

   always_ff @(posedge clk) begin
      if (is_write) mem_q[address] <= in;
   end

   // Write-through read so a write access returns the word being written.
   assign out = is_write ? in : mem_q[address];

endmodule

// File: rtl/ram_arb_pick.sv
// Combinational 2-way grant picker.
// RAM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; default is fixed port-0 priority.
module ram_arb_pick
   import ram_arb_pkg::*;
(
`ifdef RAM_ARB_ROUND_ROBIN_EN
   input  logic last_i,
`endif
   input  logic p0_req_i,
   input  logic p1_req_i,
   output logic any_o,
   output logic grant_o
);

   always_comb begin
      any_o   = p0_req_i | p1_req_i;
      grant_o = PORT_FETCH;
      if (p0_req_i && p1_req_i) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
         // On a tie the port not served last wins.
         grant_o = ~last_i;
`else
         grant_o = PORT_FETCH;
`endif
      end else if (p1_req_i) begin
         grant_o = PORT_DATA;
      end
   end

endmodule

// File: rtl/ram_arbiter_2port.sv
// Two-requester arbiter/sequencer for RAM_32bit_16aline: IDLE -> ACCESS -> RESP per access.
// RAM_ARB_ROUND_ROBIN_EN enables round-robin arbitration with a last-served register.
module ram_arbiter_2port
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = RAM_ADDR_W,
   parameter int unsigned DATA_W = RAM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_is_write,
   input  logic [ADDR_W-1:0] p0_address,
   input  logic [DATA_W-1:0] p0_in,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_out,
   input  logic              p1_req,
   input  logic              p1_is_write,
   input  logic [ADDR_W-1:0] p1_address,
   input  logic [DATA_W-1:0] p1_in,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_out,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_in,
   output logic              ram_is_write,
   input  logic [DATA_W-1:0] ram_out
);

   ram_arb_state_t    state_q, state_d;
   logic              sel_q, sel_d;
   logic              p0_ack_q, p0_ack_d;
   logic              p1_ack_q, p1_ack_d;
   logic [DATA_W-1:0] p0_out_q, p0_out_d;
   logic [DATA_W-1:0] p1_out_q, p1_out_d;
   logic              any_req;
   logic              grant;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;
`endif

   ram_arb_pick u_pick (
`ifdef RAM_ARB_ROUND_ROBIN_EN
      .last_i   (last_q),
`endif
      .p0_req_i (p0_req),
      .p1_req_i (p1_req),
      .any_o    (any_req),
      .grant_o  (grant)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sel_q    <= PORT_FETCH;
         p0_ack_q <= 1'b0;
         p1_ack_q <= 1'b0;
         p0_out_q <= '0;
         p1_out_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_q   <= PORT_FETCH;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         p0_ack_q <= p0_ack_d;
         p1_ack_q <= p1_ack_d;
         p0_out_q <= p0_out_d;
         p1_out_q <= p1_out_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_q   <= last_d;
`endif
      end
   end

   // RAM controls are decoded from state so reset kills a write immediately.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      p0_ack_d     = 1'b0;
      p1_ack_d     = 1'b0;
      p0_out_d     = p0_out_q;
      p1_out_d     = p1_out_q;
      ram_address  = p0_address;
      ram_in       = p0_in;
      ram_is_write = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_d       = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               sel_d   = grant;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (sel_q == PORT_DATA) begin
               ram_address  = p1_address;
               ram_in       = p1_in;
               ram_is_write = p1_is_write;
               p1_out_d     = ram_out;
               p1_ack_d     = 1'b1;
            end else begin
               ram_address  = p0_address;
               ram_in       = p0_in;
               ram_is_write = p0_is_write;
               p0_out_d     = ram_out;
               p0_ack_d     = 1'b1;
            end
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_d  = sel_q;
`endif
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign p0_ack = p0_ack_q;
   assign p1_ack = p1_ack_q;
   assign p0_out = p0_out_q;
   assign p1_out = p1_out_q;

endmodule

// File: tb/tb_ram_arbiter_2port.sv
// Directed self-checking bench for ram_arbiter_2port with RAM_32bit_16aline.
module tb_ram_arbiter_2port;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          reset;
   logic          p0_req, p0_is_write, p0_ack;
   logic [AW-1:0] p0_address;
   logic [DW-1:0] p0_in, p0_out;
   logic          p1_req, p1_is_write, p1_ack;
   logic [AW-1:0] p1_address;
   logic [DW-1:0] p1_in, p1_out;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_in, ram_out;
   logic          ram_is_write;

   int checks   = 0;
   int failures = 0;

   ram_arbiter_2port #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .p0_req       (p0_req),
      .p0_is_write  (p0_is_write),
      .p0_address   (p0_address),
      .p0_in        (p0_in),
      .p0_ack       (p0_ack),
      .p0_out       (p0_out),
      .p1_req       (p1_req),
      .p1_is_write  (p1_is_write),
      .p1_address   (p1_address),
      .p1_in        (p1_in),
      .p1_ack       (p1_ack),
      .p1_out       (p1_out),
      .ram_address  (ram_address),
      .ram_in       (ram_in),
      .ram_is_write (ram_is_write),
      .ram_out      (ram_out)
   );

   RAM_32bit_16aline u_ram (
      .clk      (clk),
      .address  (ram_address),
      .in       (ram_in),
      .is_write (ram_is_write),
      .out      (ram_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Complete one access on a single port; returns in IDLE at a negedge.
   task automatic do_access(input logic port, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (port) begin
         p1_req = 1'b1; p1_is_write = wr; p1_address = a; p1_in = d;
      end else begin
         p0_req = 1'b1; p0_is_write = wr; p0_address = a; p0_in = d;
      end
      tick();
      tick();
      p0_req = 1'b0;
      p1_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (ram_is_write !== 1'b0) begin failures++; $display("FAIL reset_ram_is_write got=%b exp=0", ram_is_write); end
      reset = 1'b0;
      tick();
      checks++; if (p0_ack !== 1'b0) begin failures++; $display("FAIL reset_p0_ack got=%b exp=0", p0_ack); end
      checks++; if (p1_ack !== 1'b0) begin failures++; $display("FAIL reset_p1_ack got=%b exp=0", p1_ack); end
      checks++; if (p0_out !== 32'h0) begin failures++; $display("FAIL reset_p0_out got=%h exp=0", p0_out); end
      checks++; if (p1_out !== 32'h0) begin failures++; $display("FAIL reset_p1_out got=%h exp=0", p1_out); end
   endtask

   task automatic test_write_read();
      p1_req = 1'b1; p1_is_write = 1'b1; p1_address = 16'hC3BC; p1_in = 32'hE5F84AB1;
      tick();
      checks++; if (ram_is_write !== 1'b1) begin failures++; $display("FAIL wr_access_is_write got=%b exp=1", ram_is_write); end
      checks++; if (ram_address !== 16'hC3BC) begin failures++; $display("FAIL wr_access_addr got=%h exp=c3bc", ram_address); end
      checks++; if (p1_ack !== 1'b0) begin failures++; $display("FAIL wr_early_ack got=%b exp=0", p1_ack); end
      tick();
      checks++; if (p1_ack !== 1'b1) begin failures++; $display("FAIL wr_p1_ack got=%b exp=1", p1_ack); end
      checks++; if (p1_out !== 32'hE5F84AB1) begin failures++; $display("FAIL wr_readback got=%h exp=e5f84ab1", p1_out); end
      p1_req = 1'b0; p1_is_write = 1'b0;
      tick();
      checks++; if (p1_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse got=%b exp=0", p1_ack); end
      p0_req = 1'b1; p0_is_write = 1'b0; p0_address = 16'hC3BC;
      tick();
      checks++; if (ram_is_write !== 1'b0) begin failures++; $display("FAIL rd_access_is_write got=%b exp=0", ram_is_write); end
      tick();
      checks++; if (p0_ack !== 1'b1) begin failures++; $display("FAIL rd_p0_ack got=%b exp=1", p0_ack); end
      checks++; if (p0_out !== 32'hE5F84AB1) begin failures++; $display("FAIL rd_p0_out got=%h exp=e5f84ab1", p0_out); end
      checks++; if (p1_out !== 32'hE5F84AB1) begin failures++; $display("FAIL rd_p1_out_hold got=%h exp=e5f84ab1", p1_out); end
      p0_req = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous();
      do_access(1'b0, 1'b1, 16'hB83A, 32'h12345678);
      p0_req = 1'b1; p0_is_write = 1'b1; p0_address = 16'hB83A; p0_in = 32'h5C8C6A01;
      p1_req = 1'b1; p1_is_write = 1'b0; p1_address = 16'hB83A;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      tick();
      checks++; if (ram_is_write !== 1'b0) begin failures++; $display("FAIL sim_first_is_write got=%b exp=0", ram_is_write); end
      tick();
      checks++; if (p1_ack !== 1'b1 || p0_ack !== 1'b0) begin failures++; $display("FAIL sim_first_acks got=p0:%b p1:%b exp=p0:0 p1:1", p0_ack, p1_ack); end
      checks++; if (p1_out !== 32'h12345678) begin failures++; $display("FAIL sim_p1_old got=%h exp=12345678", p1_out); end
      p1_req = 1'b0;
      tick();
      tick();
      checks++; if (ram_is_write !== 1'b1) begin failures++; $display("FAIL sim_second_is_write got=%b exp=1", ram_is_write); end
      tick();
      checks++; if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin failures++; $display("FAIL sim_second_acks got=p0:%b p1:%b exp=p0:1 p1:0", p0_ack, p1_ack); end
      checks++; if (p0_out !== 32'h5C8C6A01) begin failures++; $display("FAIL sim_p0_out got=%h exp=5c8c6a01", p0_out); end
      p0_req = 1'b0;
`else
      tick();
      checks++; if (ram_is_write !== 1'b1) begin failures++; $display("FAIL sim_first_is_write got=%b exp=1", ram_is_write); end
      tick();
      checks++; if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin failures++; $display("FAIL sim_first_acks got=p0:%b p1:%b exp=p0:1 p1:0", p0_ack, p1_ack); end
      checks++; if (p0_out !== 32'h5C8C6A01) begin failures++; $display("FAIL sim_p0_out got=%h exp=5c8c6a01", p0_out); end
      p0_req = 1'b0; p0_is_write = 1'b0;
      tick();
      tick();
      checks++; if (ram_is_write !== 1'b0) begin failures++; $display("FAIL sim_second_is_write got=%b exp=0", ram_is_write); end
      tick();
      checks++; if (p1_ack !== 1'b1 || p0_ack !== 1'b0) begin failures++; $display("FAIL sim_second_acks got=p0:%b p1:%b exp=p0:0 p1:1", p0_ack, p1_ack); end
      checks++; if (p1_out !== 32'h5C8C6A01) begin failures++; $display("FAIL sim_p1_new got=%h exp=5c8c6a01", p1_out); end
      p1_req = 1'b0;
`endif
      p0_is_write = 1'b0;
      tick();
   endtask

   task automatic test_held_request();
      int n0;
      int n1;
      int both;
      int order [4];
      int k;
      n0 = 0; n1 = 0; both = 0; k = 0;
      for (int i = 0; i < 4; i++) order[i] = -1;
      do_access(1'b1, 1'b0, 16'hC3BC, 32'h0);
      p0_req = 1'b1; p0_is_write = 1'b0; p0_address = 16'hC3BC;
      p1_req = 1'b1; p1_is_write = 1'b0; p1_address = 16'hB83A;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (p0_ack && p1_ack) both++;
         if (p0_ack) begin n0++; if (k < 4) begin order[k] = 0; k++; end end
         if (p1_ack) begin n1++; if (k < 4) begin order[k] = 1; k++; end end
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
      tick();
      checks++; if (both !== 0) begin failures++; $display("FAIL hold_double_ack got=%0d exp=0", both); end
`ifdef RAM_ARB_ROUND_ROBIN_EN
      checks++; if (n0 !== 2 || n1 !== 2) begin failures++; $display("FAIL hold_counts got=p0:%0d p1:%0d exp=p0:2 p1:2", n0, n1); end
      checks++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0) begin failures++; $display("FAIL hold_order got=%0d,%0d,%0d exp=0,1,0", order[0], order[1], order[2]); end
      checks++; if (p1_out !== 32'h5C8C6A01) begin failures++; $display("FAIL hold_p1_out got=%h exp=5c8c6a01", p1_out); end
`else
      checks++; if (n1 !== 0) begin failures++; $display("FAIL hold_p1_starve got=%0d exp=0", n1); end
      checks++; if (n0 !== 4) begin failures++; $display("FAIL hold_p0_count got=%0d exp=4", n0); end
`endif
   endtask

   task automatic test_reset_mid_access();
      do_access(1'b0, 1'b1, 16'h0001, 32'h11223344);
      p1_req = 1'b1; p1_is_write = 1'b1; p1_address = 16'h0001; p1_in = 32'hDEADBEEF;
      tick();
      checks++; if (ram_is_write !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_is_write got=%b exp=1", ram_is_write); end
      reset = 1'b1;
      #1;
      checks++; if (ram_is_write !== 1'b0) begin failures++; $display("FAIL rst_mid_is_write got=%b exp=0", ram_is_write); end
      @(negedge clk);
      reset = 1'b0;
      p1_req = 1'b0; p1_is_write = 1'b0;
      checks++; if (p1_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_ack0 got=%b exp=0", p1_ack); end
      tick();
      checks++; if (p1_ack !== 1'b0) begin failures++; $display("FAIL rst_mid_ack1 got=%b exp=0", p1_ack); end
      p0_req = 1'b1; p0_is_write = 1'b0; p0_address = 16'h0001;
      tick();
      tick();
      checks++; if (p0_ack !== 1'b1) begin failures++; $display("FAIL rst_mid_rd_ack got=%b exp=1", p0_ack); end
      checks++; if (p0_out !== 32'h11223344) begin failures++; $display("FAIL rst_mid_rd_data got=%h exp=11223344", p0_out); end
      p0_req = 1'b0;
      tick();
   endtask

   task automatic test_drop_req();
      p0_req = 1'b1; p0_is_write = 1'b0; p0_address = 16'hC3BC;
      tick();
      p0_req = 1'b0;
      tick();
      checks++; if (p0_ack !== 1'b1) begin failures++; $display("FAIL drop_ack got=%b exp=1", p0_ack); end
      checks++; if (p0_out !== 32'hE5F84AB1) begin failures++; $display("FAIL drop_data got=%h exp=e5f84ab1", p0_out); end
      tick();
      checks++; if (p0_ack !== 1'b0) begin failures++; $display("FAIL drop_ack_once got=%b exp=0", p0_ack); end
      tick();
      checks++; if (p0_ack !== 1'b0 || ram_is_write !== 1'b0) begin failures++; $display("FAIL drop_quiet got=ack:%b wr:%b exp=ack:0 wr:0", p0_ack, ram_is_write); end
      p1_req = 1'b1; p1_is_write = 1'b0; p1_address = 16'hC3BC;
      tick();
      tick();
      checks++; if (p1_ack !== 1'b1) begin failures++; $display("FAIL drop_idle_regrant got=%b exp=1", p1_ack); end
      checks++; if (p1_out !== 32'hE5F84AB1) begin failures++; $display("FAIL drop_p1_data got=%h exp=e5f84ab1", p1_out); end
      p1_req = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      p0_req = 1'b0; p0_is_write = 1'b0; p0_address = '0; p0_in = '0;
      p1_req = 1'b0; p1_is_write = 1'b0; p1_address = '0; p1_in = '0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_simultaneous();
      test_held_request();
      test_reset_mid_access();
      test_drop_req();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
